stream_packet_mux: RTL and testbench

//  Packet-granular N:1 multiplexer for ndata streams. Routes whole packets (first beat

---
 rtl/stream_packet_mux_pkg.sv | 11 +
 rtl/stream_packet_mux_skid_buffer.sv | 61 ++++++
 rtl/stream_packet_mux.sv | 128 ++++++++++++
 tb/tb_stream_packet_mux.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_packet_mux_pkg.sv
// Shared types and helpers for the packet-granular stream multiplexer.
package stream_packet_mux_pkg;

  typedef enum logic {MUX_SELECT, MUX_RR} mux_mode_t;
  typedef enum logic {IDLE, LOCKED} mux_state_t;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_packet_mux_skid_buffer.sv
// Two-entry skid buffer for ndata beats; registered ready on the input side and
// registered valid/data on the output side.
module ndata_skid_buffer #(
  parameter type         data_t       = logic [31:0],
  parameter int unsigned NUM_ELEMENTS = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  data_t [NUM_ELEMENTS-1:0]     in_data,
  input  logic  [NUM_ELEMENTS-1:0]     in_keep,
  input  logic                         in_last,
  input  logic                         in_valid,
  output logic                         in_ready,
  output data_t [NUM_ELEMENTS-1:0]     out_data,
  output logic  [NUM_ELEMENTS-1:0]     out_keep,
  output logic                         out_last,
  output logic                         out_valid,
  input  logic                         out_ready
);

  typedef struct packed {
    data_t [NUM_ELEMENTS-1:0] data;
    logic  [NUM_ELEMENTS-1:0] keep;
    logic                     last;
  } beat_t;

  beat_t      mem_q [2];
  beat_t      in_beat;
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] count_q;
  logic       push, pop;

  assign in_beat   = '{data: in_data, keep: in_keep, last: in_last};
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Read straight from storage so the head stays stable while stalled.
  assign out_data = mem_q[rd_ptr_q].data;
  assign out_keep = mem_q[rd_ptr_q].keep;
  assign out_last = mem_q[rd_ptr_q].last;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_beat;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/stream_packet_mux.sv
// Packet-granular N:1 ndata multiplexer; a source is locked from first beat to last,
// chosen by a select token or round-robin, with the output registered via a skid buffer.
module stream_packet_mux
  import stream_packet_mux_pkg::*;
#(
  parameter type         data_t       = logic [31:0],
  parameter int unsigned NUM_ELEMENTS = 8,
  parameter int unsigned NUM_STREAMS  = 4,
  parameter mux_mode_t   MODE         = MUX_SELECT,
  localparam int unsigned SEL_W       = sel_width(NUM_STREAMS)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic  [SEL_W-1:0]                         select_data,
  input  logic                                      select_valid,
  output logic                                      select_ready,
  input  data_t [NUM_STREAMS-1:0][NUM_ELEMENTS-1:0] in_data,
  input  logic  [NUM_STREAMS-1:0][NUM_ELEMENTS-1:0] in_keep,
  input  logic  [NUM_STREAMS-1:0]                   in_last,
  input  logic  [NUM_STREAMS-1:0]                   in_valid,
  output logic  [NUM_STREAMS-1:0]                   in_ready,
  output data_t [NUM_ELEMENTS-1:0]                  out_data,
  output logic  [NUM_ELEMENTS-1:0]                  out_keep,
  output logic                                      out_last,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic  [SEL_W-1:0]                         grant,
  output logic                                      grant_valid,
  output logic                                      bad_select
);

  mux_state_t state_q;
  logic [SEL_W-1:0] grant_q, rr_ptr_q, rr_pick, rr_idx;
  logic             rr_found, sel_in_range, skid_ready, mux_valid, mux_last, accept;
  data_t [NUM_ELEMENTS-1:0] mux_data;
  logic  [NUM_ELEMENTS-1:0] mux_keep;

  assign grant        = grant_q;
  assign sel_in_range = (32'(select_data) < NUM_STREAMS);

  // First valid input strictly after the pointer, wrapping around.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    rr_idx   = '0;
    for (int unsigned k = 1; k <= NUM_STREAMS; k++) begin
      rr_idx = SEL_W'((32'(rr_ptr_q) + k) % NUM_STREAMS);
      if (!rr_found && in_valid[rr_idx]) begin
        rr_found = 1'b1;
        rr_pick  = rr_idx;
      end
    end
  end

  assign mux_data  = in_data[grant_q];
  assign mux_keep  = in_keep[grant_q];
  assign mux_last  = in_last[grant_q];
  assign mux_valid = (state_q == LOCKED) && in_valid[grant_q];
  assign accept    = mux_valid && skid_ready;

  always_comb begin
    in_ready = '0;
    if (state_q == LOCKED) in_ready[grant_q] = skid_ready;
  end

  // Tokens are consumed with the last beat, or dropped at once when out of range.
  always_comb begin
    select_ready = 1'b0;
    if (MODE == MUX_SELECT) begin
      if (state_q == IDLE) select_ready = select_valid && !sel_in_range;
      else                 select_ready = accept && mux_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      grant_valid <= 1'b0;
      bad_select  <= 1'b0;
      rr_ptr_q    <= SEL_W'(NUM_STREAMS - 1);
    end else begin
      unique case (state_q)
        IDLE: begin
          if (MODE == MUX_SELECT) begin
            if (select_valid && sel_in_range) begin
              grant_q     <= select_data;
              grant_valid <= 1'b1;
              state_q     <= LOCKED;
            end else if (select_valid) begin
              bad_select <= 1'b1;
            end
          end else if (rr_found) begin
            grant_q     <= rr_pick;
            grant_valid <= 1'b1;
            state_q     <= LOCKED;
          end
        end
        LOCKED: begin
          if (accept && mux_last) begin
            grant_valid <= 1'b0;
            state_q     <= IDLE;
            if (MODE == MUX_RR) rr_ptr_q <= grant_q;
          end
        end
      endcase
    end
  end

  ndata_skid_buffer #(
    .data_t      (data_t),
    .NUM_ELEMENTS(NUM_ELEMENTS)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_data  (mux_data),
    .in_keep  (mux_keep),
    .in_last  (mux_last),
    .in_valid (mux_valid),
    .in_ready (skid_ready),
    .out_data (out_data),
    .out_keep (out_keep),
    .out_last (out_last),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

endmodule

// File: tb/tb_stream_packet_mux.sv
// Directed bench: a select-mode mux (5 streams, so select=7 is representable and out of
// range) and a round-robin mux (4 streams), each with 2 elements per beat.
module tb_stream_packet_mux;
  import stream_packet_mux_pkg::*;

  localparam int unsigned SN = 5;
  localparam int unsigned RN = 4;
  localparam int unsigned NE = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [SN-1:0][NE-1:0][31:0] s_in_data;
  logic [SN-1:0][NE-1:0]       s_in_keep;
  logic [SN-1:0]               s_in_last, s_in_valid, s_in_ready;
  logic [NE-1:0][31:0]         s_out_data;
  logic [NE-1:0]               s_out_keep;
  logic                        s_out_last, s_out_valid, s_out_ready;
  logic [2:0]                  s_sel_data, s_grant;
  logic                        s_sel_valid, s_sel_ready, s_grant_valid, s_bad;

  logic [RN-1:0][NE-1:0][31:0] r_in_data;
  logic [RN-1:0][NE-1:0]       r_in_keep;
  logic [RN-1:0]               r_in_last, r_in_valid, r_in_ready;
  logic [NE-1:0][31:0]         r_out_data;
  logic [NE-1:0]               r_out_keep;
  logic                        r_out_last, r_out_valid, r_out_ready;
  logic [1:0]                  r_sel_data, r_grant;
  logic                        r_sel_valid, r_sel_ready, r_grant_valid, r_bad;

  stream_packet_mux #(
    .data_t(logic [31:0]), .NUM_ELEMENTS(NE), .NUM_STREAMS(SN), .MODE(MUX_SELECT)
  ) dut_s (
    .clk(clk), .rst(rst),
    .select_data(s_sel_data), .select_valid(s_sel_valid), .select_ready(s_sel_ready),
    .in_data(s_in_data), .in_keep(s_in_keep), .in_last(s_in_last),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .out_data(s_out_data), .out_keep(s_out_keep), .out_last(s_out_last),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .grant(s_grant), .grant_valid(s_grant_valid), .bad_select(s_bad)
  );

  stream_packet_mux #(
    .data_t(logic [31:0]), .NUM_ELEMENTS(NE), .NUM_STREAMS(RN), .MODE(MUX_RR)
  ) dut_r (
    .clk(clk), .rst(rst),
    .select_data(r_sel_data), .select_valid(r_sel_valid), .select_ready(r_sel_ready),
    .in_data(r_in_data), .in_keep(r_in_keep), .in_last(r_in_last),
    .in_valid(r_in_valid), .in_ready(r_in_ready),
    .out_data(r_out_data), .out_keep(r_out_keep), .out_last(r_out_last),
    .out_valid(r_out_valid), .out_ready(r_out_ready),
    .grant(r_grant), .grant_valid(r_grant_valid), .bad_select(r_bad)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic s_beat(input int i, input logic [31:0] base, input logic [1:0] keep,
                        input logic last);
    s_in_data[i][0] = base;
    s_in_data[i][1] = base + 32'd1;
    s_in_keep[i]    = keep;
    s_in_last[i]    = last;
  endtask

  // Round-robin source model: each input walks its own packet/beat counters.
  int r_beat[RN];
  int r_pkt[RN];
  int r_len;

  task automatic r_drive();
    for (int i = 0; i < int'(RN); i++) begin
      r_in_data[i][0] = {8'(i), 8'(r_pkt[i]), 8'(r_beat[i]), 8'h00};
      r_in_data[i][1] = ~r_in_data[i][0];
      r_in_keep[i]    = '1;
      r_in_last[i]    = (r_beat[i] == r_len - 1);
    end
  endtask

  int          order[9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
  int          lens[9]  = '{2, 2, 2, 2, 2, 1, 1, 1, 1};
  int          exp_src[$];
  int          n_grant, n_done;
  logic        prev_gv;
  logic [RN-1:0] acc;

  initial begin
    rst = 1'b1;
    s_in_data = '0; s_in_keep = '0; s_in_last = '0; s_in_valid = '0; s_out_ready = 1'b1;
    s_sel_data = '0; s_sel_valid = 1'b0;
    r_in_data = '0; r_in_keep = '0; r_in_last = '0; r_in_valid = '0; r_out_ready = 1'b1;
    r_sel_data = 2'd2; r_sel_valid = 1'b1;
    for (int i = 0; i < int'(RN); i++) begin r_beat[i] = 0; r_pkt[i] = 0; end
    r_len = 2;
    repeat (3) step();

    // Reset state
    check("rst_s_out_valid", 64'(s_out_valid), 64'(0));
    check("rst_s_in_ready", 64'(s_in_ready), 64'(0));
    check("rst_s_sel_ready", 64'(s_sel_ready), 64'(0));
    check("rst_s_grant", 64'(s_grant), 64'(0));
    check("rst_s_grant_valid", 64'(s_grant_valid), 64'(0));
    check("rst_s_bad", 64'(s_bad), 64'(0));
    check("rst_r_in_ready", 64'(r_in_ready), 64'(0));
    check("rst_r_out_valid", 64'(r_out_valid), 64'(0));

    // 1: select=2, three beats from in[2]; middle beat has zero keep
    rst = 1'b0;
    s_sel_data = 3'd2; s_sel_valid = 1'b1;
    s_beat(2, 32'h20, 2'b11, 1'b0); s_in_valid = 5'b00100;
    step();
    check("t1_grant_valid", 64'(s_grant_valid), 64'(1));
    check("t1_grant", 64'(s_grant), 64'(2));
    check("t1_in_ready", 64'(s_in_ready), 64'(5'b00100));
    check("t1_out_valid_pre", 64'(s_out_valid), 64'(0));
    step();
    check("t1_out_b0", 64'(s_out_data), 64'h00000021_00000020);
    check("t1_out_valid", 64'(s_out_valid), 64'(1));
    s_beat(2, 32'h22, 2'b00, 1'b0);
    #1 check("t1_sel_ready_b1", 64'(s_sel_ready), 64'(0));
    step();
    check("t1_out_b1", 64'(s_out_data), 64'h00000023_00000022);
    check("t1_out_keep0", 64'(s_out_keep), 64'(0));
    s_beat(2, 32'h24, 2'b11, 1'b1);
    #1 check("t1_sel_ready_b2", 64'(s_sel_ready), 64'(1));
    step();
    check("t1_out_b2", 64'(s_out_data), 64'h00000025_00000024);
    check("t1_out_last", 64'(s_out_last), 64'(1));
    check("t1_grant_valid_end", 64'(s_grant_valid), 64'(0));
    s_in_valid = '0; s_sel_valid = 1'b0;
    #1 check("t1_sel_ready_idle", 64'(s_sel_ready), 64'(0));
    step();
    check("t1_out_drained", 64'(s_out_valid), 64'(0));

    // 2: in[0] and in[1] both valid, select=1, select changes mid-packet
    s_beat(0, 32'h100, 2'b11, 1'b0); s_beat(1, 32'h40, 2'b11, 1'b0);
    s_in_valid = 5'b00011; s_sel_data = 3'd1; s_sel_valid = 1'b1;
    step();
    check("t2_in_ready", 64'(s_in_ready), 64'(5'b00010));
    s_sel_data = 3'd0;
    step();
    check("t2_out_b0", 64'(s_out_data), 64'h00000041_00000040);
    check("t2_grant_hold", 64'(s_grant), 64'(1));
    check("t2_in_ready_hold", 64'(s_in_ready), 64'(5'b00010));
    s_beat(1, 32'h42, 2'b11, 1'b1);
    #1 check("t2_sel_ready", 64'(s_sel_ready), 64'(1));
    step();
    check("t2_out_b1", 64'(s_out_data), 64'h00000043_00000042);
    check("t2_grant_valid_end", 64'(s_grant_valid), 64'(0));
    s_in_valid = '0; s_sel_valid = 1'b0;
    step();
    check("t2_out_drained", 64'(s_out_valid), 64'(0));

    // 3: out-of-range token dropped, then select=0 single-beat packet
    s_sel_data = 3'd7; s_sel_valid = 1'b1;
    #1 check("t3_drop_ready", 64'(s_sel_ready), 64'(1));
    step();
    check("t3_bad_select", 64'(s_bad), 64'(1));
    check("t3_no_grant", 64'(s_grant_valid), 64'(0));
    check("t3_no_out", 64'(s_out_valid), 64'(0));
    s_sel_data = 3'd0; s_beat(0, 32'h50, 2'b01, 1'b1); s_in_valid = 5'b00001;
    #1 check("t3_sel_ready_hold", 64'(s_sel_ready), 64'(0));
    step();
    check("t3_grant", 64'(s_grant), 64'(0));
    check("t3_in_ready", 64'(s_in_ready), 64'(5'b00001));
    #1 check("t3_sel_ready_last", 64'(s_sel_ready), 64'(1));
    step();
    check("t3_out", 64'(s_out_data), 64'h00000051_00000050);
    check("t3_out_keep", 64'(s_out_keep), 64'(2'b01));
    check("t3_bad_sticky", 64'(s_bad), 64'(1));
    check("t3_grant_valid_end", 64'(s_grant_valid), 64'(0));
    s_in_valid = '0; s_sel_valid = 1'b0;
    step();
    check("t3_out_drained", 64'(s_out_valid), 64'(0));

    // 4: backpressure on a 4-beat packet from in[4] (highest legal index)
    s_sel_data = 3'd4; s_sel_valid = 1'b1;
    s_beat(4, 32'h60, 2'b11, 1'b0); s_in_valid = 5'b10000;
    step();
    check("t4_grant", 64'(s_grant), 64'(4));
    step();
    check("t4_out_b0", 64'(s_out_data), 64'h00000061_00000060);
    s_beat(4, 32'h62, 2'b11, 1'b0); s_out_ready = 1'b1;
    step();
    check("t4_out_b1", 64'(s_out_data), 64'h00000063_00000062);
    s_beat(4, 32'h64, 2'b11, 1'b0); s_out_ready = 1'b0;
    step();
    check("t4_stall1_data", 64'(s_out_data), 64'h00000063_00000062);
    check("t4_full_ready", 64'(s_in_ready), 64'(0));
    s_beat(4, 32'h66, 2'b11, 1'b1);
    step();
    check("t4_stall2_data", 64'(s_out_data), 64'h00000063_00000062);
    check("t4_stall2_valid", 64'(s_out_valid), 64'(1));
    check("t4_stall2_ready", 64'(s_in_ready), 64'(0));
    s_out_ready = 1'b1;
    step();
    check("t4_out_b2", 64'(s_out_data), 64'h00000065_00000064);
    check("t4_ready_back", 64'(s_in_ready), 64'(5'b10000));
    #1 check("t4_sel_ready", 64'(s_sel_ready), 64'(1));
    step();
    check("t4_out_b3", 64'(s_out_data), 64'h00000067_00000066);
    check("t4_out_last", 64'(s_out_last), 64'(1));
    s_in_valid = '0; s_sel_valid = 1'b0;
    step();
    check("t4_out_drained", 64'(s_out_valid), 64'(0));

    // 5: round-robin with every input always valid; 2-beat then 1-beat packets
    r_drive(); r_in_valid = '1;
    #1 check("t5_sel_ignored", 64'(r_sel_ready), 64'(0));
    n_grant = 0; n_done = 0; prev_gv = 1'b0;
    for (int cyc = 0; cyc < 80 && n_done < 9; cyc++) begin
      acc = r_in_ready & r_in_valid;
      step();
      for (int i = 0; i < int'(RN); i++) begin
        if (acc[i]) begin
          r_beat[i]++;
          if (r_beat[i] == r_len) begin r_beat[i] = 0; r_pkt[i]++; end
        end
      end
      if (r_out_valid) begin
        if (exp_src.size() == 0) check("t5_out_unexpected", 64'(r_out_valid), 64'(0));
        else check("t5_out_src", 64'(r_out_data[0][31:24]), 64'(exp_src.pop_front()));
      end
      if (r_grant_valid && !prev_gv && n_grant < 9) begin
        check("t5_grant", 64'(r_grant), 64'(order[n_grant]));
        for (int b = 0; b < lens[n_grant]; b++) exp_src.push_back(order[n_grant]);
        n_grant++;
      end
      if (r_grant_valid && n_grant > 0)
        check("t5_in_ready_onehot", 64'(r_in_ready), 64'(1 << order[n_grant-1]));
      if (!r_grant_valid && prev_gv) begin
        n_done++;
        if (n_done < 9) r_len = lens[n_done];
      end
      prev_gv = r_grant_valid;
      r_drive();
      #1;
    end
    check("t5_packets_done", 64'(n_done), 64'(9));
    check("t5_all_beats_out", 64'(exp_src.size()), 64'(0));
    r_in_valid = '0;

    // 6: reset mid-packet, then a clean packet afterwards
    s_sel_data = 3'd1; s_sel_valid = 1'b1;
    s_beat(1, 32'h80, 2'b11, 1'b0); s_in_valid = 5'b00010;
    step();
    step();
    check("t6_pre_out", 64'(s_out_valid), 64'(1));
    rst = 1'b1;
    step();
    check("t6_out_valid", 64'(s_out_valid), 64'(0));
    check("t6_grant_valid", 64'(s_grant_valid), 64'(0));
    check("t6_in_ready", 64'(s_in_ready), 64'(0));
    check("t6_bad_cleared", 64'(s_bad), 64'(0));
    check("t6_r_in_ready", 64'(r_in_ready), 64'(0));
    #1 check("t6_sel_ready", 64'(s_sel_ready), 64'(0));
    rst = 1'b0;
    s_beat(1, 32'h70, 2'b11, 1'b1);
    step();
    check("t6_regrant", 64'(s_grant), 64'(1));
    check("t6_regrant_valid", 64'(s_grant_valid), 64'(1));
    #1 check("t6_sel_ready_last", 64'(s_sel_ready), 64'(1));
    step();
    check("t6_out", 64'(s_out_data), 64'h00000071_00000070);
    check("t6_out_last", 64'(s_out_last), 64'(1));
    s_in_valid = '0; s_sel_valid = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
